// File: rtl/load_buffer.sv
// -----------------------------------------------------------------------------
// load_buffer
//   In-order load queue between address calculation and data memory. Loads are
//   held in a circular FIFO. The head entry issues one word-aligned memory read
//   at a time. Byte and half loads are extracted and sign/zero-extended, then
//   the result is offered on the CDB until it is granted. A branch kill squashes
//   the speculative tail of the queue, including a head load already in flight.
//   A branch resolve clears every speculative flag.
//
// Ports
//   clock, reset           clock; synchronous active-high reset
//   lb_packet_in           incoming load (LB_PACKET), enqueued when .valid
//   kill / resolve         branch mispredict / branch correct
//   lb_full                queue full, upstream must stall
//   mem_req_valid/_addr    read request (word aligned); mem_req_ready accepts it
//   mem_resp_valid/_data   read response
//   load_result            CDB packet (EX_WR_PACKET); cdb_grant accepts it
//
// Optional: define LB_PERF_EN to add the 32-bit counters lb_loads_done and
//   lb_loads_killed.
// -----------------------------------------------------------------------------
package lb_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] address;
    logic [TAG_W-1:0] rd_tag;
    logic [2:0]      mem_size;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] inst;
    logic            speculative;
  } LB_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] value;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] inst;
    logic            speculative;
  } EX_WR_PACKET;
endpackage

module load_buffer
  import lb_pkg::*;
#(
  parameter int unsigned LB_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  LB_PACKET        lb_packet_in,
  input  logic            kill,
  input  logic            resolve,
  output logic            lb_full,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output EX_WR_PACKET     load_result,
  input  logic            cdb_grant
`ifdef LB_PERF_EN
  ,
  output logic [31:0]     lb_loads_done,
  output logic [31:0]     lb_loads_killed
`endif
);
  localparam int unsigned PW = $clog2(LB_DEPTH);
  localparam int unsigned CW = $clog2(LB_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  address;
    logic [TAG_W-1:0] rd_tag;
    logic [2:0]       mem_size;
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  inst;
    logic             speculative;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  entry_t          entry_q [LB_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  state_e          state_q;
  logic            drop_q;
  logic [XLEN-1:0] value_q;

  entry_t          head_e;
  logic            head_kill, pop, enq;
  logic [CW-1:0]   keep, base, count_d;
  logic [PW-1:0]   head_d, wr_idx, idx;
  logic [XLEN-1:0] extracted;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                               input logic [1:0] off,
                                               input logic [2:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    head_e    = entry_q[head_q];
    head_kill = kill && (count_q != '0) && head_e.speculative;
    pop       = (state_q == WB) && cdb_grant && !head_kill;
    // Speculative entries are a contiguous suffix, so the survivors of a kill
    // are exactly the non-speculative occupied entries counted from the head.
    keep = '0;
    idx  = '0;
    for (int unsigned i = 0; i < LB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && !entry_q[idx].speculative)
        keep = keep + CW'(1);
    end
    base      = kill ? (keep - CW'(pop)) : (count_q - CW'(pop));
    enq       = lb_packet_in.valid && !lb_full && !(kill && lb_packet_in.speculative);
    head_d    = head_q + PW'(pop);
    // On a kill the tail is rebuilt from the surviving count.
    wr_idx    = kill ? (head_d + PW'(base)) : tail_q;
    count_d   = base + CW'(enq);
    extracted = extract(mem_resp_data, head_e.address[1:0], head_e.mem_size);
  end

  assign lb_full       = (count_q == CW'(LB_DEPTH));
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = (state_q == REQ) ? {head_e.address[XLEN-1:2], 2'b00} : '0;

  always_comb begin
    load_result = '0;
    if (state_q == WB) begin
      load_result.valid       = 1'b1;
      load_result.value       = value_q;
      load_result.rob_tag     = head_e.rd_tag;
      load_result.NPC         = head_e.npc;
      load_result.inst        = head_e.inst;
      load_result.speculative = head_e.speculative && !resolve;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LB_DEPTH; i++) entry_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      drop_q  <= 1'b0;
      value_q <= '0;
    end else begin
      if (resolve && !kill)
        for (int unsigned i = 0; i < LB_DEPTH; i++) entry_q[i].speculative <= 1'b0;
      if (enq)
        entry_q[wr_idx] <= entry_t'{address:     lb_packet_in.address,
                                    rd_tag:      lb_packet_in.rd_tag,
                                    mem_size:    lb_packet_in.mem_size,
                                    npc:         lb_packet_in.NPC,
                                    inst:        lb_packet_in.inst,
                                    speculative: lb_packet_in.speculative && !resolve};
      head_q  <= head_d;
      tail_q  <= wr_idx + PW'(enq);
      count_q <= count_d;

      // A killed head is removed by the count truncation above; drop_q only
      // remembers that one outstanding response must be swallowed.
      case (state_q)
        IDLE: if ((count_q != '0) && !head_kill) state_q <= REQ;
        REQ: begin
          if (head_kill) begin
            if (mem_req_ready) begin
              drop_q  <= 1'b1;
              state_q <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end else if (mem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else if (head_kill) begin
              state_q <= IDLE;
            end else begin
              value_q <= extracted;
              state_q <= WB;
            end
          end else if (head_kill) begin
            drop_q <= 1'b1;
          end
        end
        WB: if (head_kill || cdb_grant) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      lb_loads_done   <= '0;
      lb_loads_killed <= '0;
    end else begin
      if (pop)  lb_loads_done   <= lb_loads_done + 32'd1;
      if (kill) lb_loads_killed <= lb_loads_killed + 32'(count_q - keep);
    end
  end
`endif

endmodule

// File: tb/tb_load_buffer.sv
module tb_load_buffer;
  import lb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  LB_PACKET    lb_packet_in;
  logic        kill, resolve, lb_full;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, cdb_grant;
  logic [31:0] mem_req_addr, mem_resp_data;
  EX_WR_PACKET load_result;

  load_buffer #(.LB_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .lb_packet_in(lb_packet_in),
    .kill(kill), .resolve(resolve), .lb_full(lb_full),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .load_result(load_result),
    .cdb_grant(cdb_grant)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of loads still owed a CDB result, in program order.
  typedef struct {
    logic [31:0] addr;
    logic [4:0]  tag;
    logic [2:0]  sz;
    logic [31:0] npc;
    logic [31:0] inst;
    logic        spec;
  } mload_t;

  mload_t      mq[$];
  logic [31:0] ret_log[$];
  logic [31:0] ovr[logic [31:0]];
  bit          retire_pend, m_full;
  int unsigned n_cmp = 0, n_err = 0, n_retired = 0;
  int unsigned resp_lat = 0, wcnt = 0;
  bit          fire_n = 0, busy = 0;
  logic [31:0] addr_n, paddr, exp_v;
  logic [4:0]  tag_ctr = 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_val(input logic [31:0] a, input logic [2:0] sz);
    int unsigned w, off, b, h;
    w   = memword({a[31:2], 2'b00});
    off = a % 4;
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (16 * (off / 2))) % 65536;
    case (sz)
      3'b000:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic LB_PACKET mkpkt(input logic [31:0] a, input logic [2:0] sz, input logic sp);
    LB_PACKET p;
    p.valid       = 1'b1;
    p.address     = a;
    p.rd_tag      = tag_ctr;
    p.mem_size    = sz;
    p.NPC         = $urandom;
    p.inst        = $urandom;
    p.speculative = sp;
    tag_ctr       = tag_ctr + 5'd1;
    return p;
  endfunction

  // Model update on each edge: kill/resolve, then enqueue.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      retire_pend = 0;
    end else begin
      m_full = (mq.size() + int'(retire_pend)) == DEPTH;
      if (kill) begin
        while (mq.size() != 0 && mq[$].spec) void'(mq.pop_back());
      end else if (resolve) begin
        foreach (mq[i]) mq[i].spec = 1'b0;
      end
      if (lb_packet_in.valid && !m_full && !(kill && lb_packet_in.speculative))
        mq.push_back('{addr: lb_packet_in.address, tag: lb_packet_in.rd_tag,
                       sz: lb_packet_in.mem_size, npc: lb_packet_in.NPC,
                       inst: lb_packet_in.inst,
                       spec: lb_packet_in.speculative && !resolve});
      retire_pend = 0;
    end
  end

  // Monitor: compares DUT outputs against the model away from the clock edge.
  always @(negedge clock) begin
    fire_n = !reset && mem_req_valid && mem_req_ready;
    addr_n = mem_req_addr;
    if (!reset) begin
      chk("lb_full", 32'(lb_full), 32'(mq.size() == DEPTH));
      if (mem_req_valid) begin
        if (mq.size() == 0) chk("req_when_empty", 32'(mem_req_valid), 32'd0);
        else if (mem_req_ready) chk("req_addr", mem_req_addr, {mq[0].addr[31:2], 2'b00});
      end
      if (load_result.valid) begin
        if (mq.size() == 0) begin
          chk("result_when_empty", 32'(load_result.valid), 32'd0);
        end else if (cdb_grant && !(kill && mq[0].spec)) begin
          exp_v = exp_val(mq[0].addr, mq[0].sz);
          chk("value", load_result.value, exp_v);
          chk("rob_tag", 32'(load_result.rob_tag), 32'(mq[0].tag));
          chk("npc", load_result.NPC, mq[0].npc);
          chk("inst", load_result.inst, mq[0].inst);
          chk("spec", 32'(load_result.speculative), 32'(mq[0].spec && !resolve));
          ret_log.push_back(load_result.value);
          n_retired++;
          void'(mq.pop_front());
          retire_pend = 1;
        end
      end
    end
  end

  // Memory responder: one outstanding read, answered resp_lat cycles later.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;
      if (reset) begin
        busy = 0;
      end else begin
        if (fire_n) begin
          busy  = 1;
          paddr = addr_n;
          wcnt  = resp_lat;
        end
        if (busy) begin
          if (wcnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = memword(paddr);
            busy = 0;
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input LB_PACKET p);
    lb_packet_in = p;
    tick(1);
    lb_packet_in = '0;
  endtask

  task automatic pulse_kill();
    kill = 1'b1; tick(1); kill = 1'b0;
  endtask

  task automatic wait_busy();
    int unsigned n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("wait_req_timeout", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((mq.size() != 0 || load_result.valid || busy || mem_req_valid) && n < budget) begin
      tick(1); n++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  function automatic logic [31:0] ret_at(input int back);
    if (ret_log.size() < back) return 32'hDEAD_BEEF;
    return ret_log[ret_log.size() - back];
  endfunction

  initial begin
    int unsigned lat, r0, r;
    bit spec_mode;
    reset = 1'b1; lb_packet_in = '0; kill = 1'b0; resolve = 1'b0;
    mem_req_ready = 1'b0; cdb_grant = 1'b0;
    tick(3);
    chk("rst_full", 32'(lb_full), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_result", 32'(|load_result), 32'd0);
    reset = 1'b0;
    tick(2);

    // LW with immediate memory and grant: latency and value.
    ovr[32'h100] = 32'h8000_00F0;
    mem_req_ready = 1'b1; cdb_grant = 1'b1; resp_lat = 0;
    lb_packet_in = mkpkt(32'h100, 3'b010, 1'b0);
    tick(1);
    lb_packet_in = '0;
    lat = 0;
    while (!load_result.valid && lat < 20) begin tick(1); lat++; end
    chk("lw_latency", lat, 32'd3);
    drain(50);
    chk("lw_value", ret_at(1), 32'h8000_00F0);

    // Sub-word extraction.
    ovr[32'h200] = 32'h80FF_7F01;
    send(mkpkt(32'h203, 3'b000, 1'b0));
    send(mkpkt(32'h203, 3'b100, 1'b0));
    send(mkpkt(32'h202, 3'b001, 1'b0));
    send(mkpkt(32'h202, 3'b101, 1'b0));
    drain(100);
    chk("lb_value",  ret_at(4), 32'hFFFF_FF80);
    chk("lbu_value", ret_at(3), 32'h0000_0080);
    chk("lh_value",  ret_at(2), 32'hFFFF_80FF);
    chk("lhu_value", ret_at(1), 32'h0000_80FF);

    // Fill to full with grant withheld; a fifth load is ignored.
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) send(mkpkt($urandom & 32'h3FF, 3'b010, 1'b0));
    chk("full_after_4", 32'(lb_full), 32'd1);
    r0 = n_retired;
    send(mkpkt(32'h44, 3'b010, 1'b0));
    chk("full_after_5th", 32'(lb_full), 32'd1);
    cdb_grant = 1'b1;
    drain(100);
    chk("full_drain_count", n_retired - r0, 32'd4);
    chk("full_drain_empty", 32'(lb_full), 32'd0);

    // Kill with two speculative entries behind a head in WAIT.
    cdb_grant = 1'b0; resp_lat = 10;
    send(mkpkt(32'h10, 3'b010, 1'b0));
    send(mkpkt(32'h14, 3'b001, 1'b0));
    send(mkpkt(32'h18, 3'b000, 1'b1));
    send(mkpkt(32'h1C, 3'b010, 1'b1));
    wait_busy();
    r0 = n_retired;
    pulse_kill();
    cdb_grant = 1'b1;
    drain(100);
    chk("kill_tail_count", n_retired - r0, 32'd2);

    // Speculative head in WAIT killed; its late response must be discarded.
    resp_lat = 2;
    send(mkpkt(32'h300, 3'b010, 1'b1));
    wait_busy();
    r0 = n_retired;
    pulse_kill();
    tick(8);
    chk("kill_head_no_result", n_retired - r0, 32'd0);
    chk("kill_head_idle_req", 32'(mem_req_valid), 32'd0);
    chk("kill_head_idle_res", 32'(load_result.valid), 32'd0);
    send(mkpkt(32'h304, 3'b010, 1'b0));
    drain(50);
    chk("after_kill_next_load", n_retired - r0, 32'd1);

    // Resolve then kill: nothing is squashed.
    cdb_grant = 1'b0; resp_lat = 0;
    send(mkpkt(32'h20, 3'b101, 1'b1));
    send(mkpkt(32'h24, 3'b000, 1'b1));
    r0 = n_retired;
    resolve = 1'b1; tick(1); resolve = 1'b0;
    pulse_kill();
    cdb_grant = 1'b1;
    drain(50);
    chk("resolve_count", n_retired - r0, 32'd2);

    // Randomised traffic.
    spec_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_req_ready = ($urandom % 4) != 0;
      cdb_grant     = ($urandom % 3) != 0;
      resp_lat      = $urandom % 3;
      kill = 1'b0; resolve = 1'b0;
      r = $urandom % 100;
      if (r < 4) kill = 1'b1;
      else if (r < 8) resolve = 1'b1;
      if ($urandom % 2 == 1) begin
        if (!spec_mode && ($urandom % 4 == 0)) spec_mode = 1;
        lb_packet_in = mkpkt($urandom & 32'h3FF, 3'($urandom), spec_mode);
      end else begin
        lb_packet_in = '0;
      end
      if (kill || resolve) spec_mode = 0;
      tick(1);
    end
    lb_packet_in = '0; kill = 1'b0; resolve = 1'b0;
    mem_req_ready = 1'b1; cdb_grant = 1'b1;
    drain(300);

    // Reset dominates a full queue with kill and a valid packet present.
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) send(mkpkt($urandom & 32'h3FF, 3'b010, 1'b0));
    reset = 1'b1; kill = 1'b1; lb_packet_in = mkpkt(32'h80, 3'b010, 1'b0);
    tick(1);
    chk("rst2_full", 32'(lb_full), 32'd0);
    chk("rst2_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst2_req_addr", mem_req_addr, 32'd0);
    chk("rst2_result", 32'(|load_result), 32'd0);
    reset = 1'b0; kill = 1'b0; lb_packet_in = '0;
    cdb_grant = 1'b1;
    r0 = n_retired;
    send(mkpkt(32'h100, 3'b010, 1'b0));
    drain(50);
    chk("post_reset_load", n_retired - r0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
